bus_arbiter: RTL and testbench

- Next-generation shared bus. N clients contend for one WIDTH-bit output channel.
- Replaces the fixed time-slot rotation with work-conserving round-robin: idle clients are skipped.
- Adds per-client valid/sent handshake, a registered output with consumer backpressure (valid/ready), and configurable burst ownership.
- Sits between client producers and a single downstream consumer.

---
 rtl/bus_arbiter_if.sv | 23 ++
 rtl/bus_arbiter.sv | 99 +++++++++
 tb/tb_bus_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Shared-bus handshake bundle: per-client requests in, one registered beat out.
// master is the arbiter side, slave is the clients/consumer side.
interface bus_arbiter_if #(
  parameter int WIDTH   = 2,
  parameter int CLIENTS = 4
);
  logic [CLIENTS-1:0][WIDTH-1:0] messages;
  logic [CLIENTS-1:0]            write;
  logic [CLIENTS-1:0]            sent;
  logic [WIDTH-1:0]              message;
  logic                          valid;
  logic                          ready;

  modport master (
    input  messages, write, ready,
    output sent, message, valid
  );

  modport slave (
    output messages, write, ready,
    input  sent, message, valid
  );
endinterface

// File: rtl/bus_arbiter.sv
// Work-conserving round-robin bus arbiter with burst ownership and valid/ready output.
// Optional BUS_FIXED_PRIO_EN makes client 0 strict-priority without disturbing rotation.
module bus_arbiter #(
  parameter int WIDTH     = 2,
  parameter int CLIENTS   = 4,
  parameter int MAX_BURST = 1
) (
  input logic           clock,
  input logic           reset,
  bus_arbiter_if.master bus
);
  localparam int RW = $clog2(CLIENTS);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic { IDLE, OWNED } state_t;

  state_t        state;
  logic [RW-1:0] rr;
  logic [CW-1:0] cnt;
  logic          load;
  logic          hit;
  logic          prio;
  logic [RW-1:0] win;

  function automatic logic [RW-1:0] inc(input logic [RW-1:0] x);
    return (x == RW'(CLIENTS - 1)) ? '0 : x + 1'b1;
  endfunction

  assign load = !bus.valid || bus.ready;

  always_comb begin
    int j;
    hit  = 1'b0;
    prio = 1'b0;
    win  = '0;
    j    = 0;
    for (int i = 0; i < CLIENTS; i++) begin
      j = int'(rr) + i;
      if (j >= CLIENTS) j -= CLIENTS;
      if (!hit && bus.write[j]) begin
        hit = 1'b1;
        win = RW'(j);
      end
    end
`ifdef BUS_FIXED_PRIO_EN
    if (bus.write[0]) begin
      hit  = 1'b1;
      prio = 1'b1;
      win  = '0;
    end
`endif
  end

  always_comb begin
    bus.sent = '0;
    if (!reset && load && hit) bus.sent[win] = 1'b1;
  end

  // While OWNED, rr points at the owner, so the scan naturally favours it.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.valid   <= 1'b0;
      bus.message <= '0;
      rr          <= '0;
      cnt         <= '0;
      state       <= IDLE;
    end else if (load) begin
      if (hit) begin
        bus.message <= bus.messages[win];
        bus.valid   <= 1'b1;
      end else begin
        bus.valid   <= 1'b0;
      end
      if (hit && !prio) begin
        if (state == OWNED && win == rr) begin
          if (int'(cnt) + 1 >= MAX_BURST) begin
            rr    <= inc(win);
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end else if (MAX_BURST == 1) begin
          rr    <= inc(win);
          cnt   <= '0;
          state <= IDLE;
        end else begin
          rr    <= win;
          cnt   <= CW'(1);
          state <= OWNED;
        end
      end else if (!hit && state == OWNED) begin
        rr    <= inc(rr);
        cnt   <= '0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three configurations driven in lockstep and
// compared every cycle against a queue-free owner/streak reference model.
module tb_bus_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bus_arbiter_if #(.WIDTH(4), .CLIENTS(4)) ia ();
  bus_arbiter_if #(.WIDTH(4), .CLIENTS(4)) ib ();
  bus_arbiter_if #(.WIDTH(4), .CLIENTS(3)) ic ();

  bus_arbiter #(.WIDTH(4), .CLIENTS(4), .MAX_BURST(1)) dut_a (
    .clock(clock), .reset(reset), .bus(ia.master));
  bus_arbiter #(.WIDTH(4), .CLIENTS(4), .MAX_BURST(3)) dut_b (
    .clock(clock), .reset(reset), .bus(ib.master));
  bus_arbiter #(.WIDTH(4), .CLIENTS(3), .MAX_BURST(2)) dut_c (
    .clock(clock), .reset(reset), .bus(ic.master));

  logic [3:0] wr_s [3];
  logic [3:0] mg_s [3][4];
  logic       rdy_s [3];

  assign ia.write    = wr_s[0];
  assign ia.ready    = rdy_s[0];
  assign ia.messages = {mg_s[0][3], mg_s[0][2], mg_s[0][1], mg_s[0][0]};
  assign ib.write    = wr_s[1];
  assign ib.ready    = rdy_s[1];
  assign ib.messages = {mg_s[1][3], mg_s[1][2], mg_s[1][1], mg_s[1][0]};
  assign ic.write    = wr_s[2][2:0];
  assign ic.ready    = rdy_s[2];
  assign ic.messages = {mg_s[2][2], mg_s[2][1], mg_s[2][0]};

  int vecs = 0;
  int errs = 0;
  logic [3:0] ex [3];
  logic [3:0] want;

  // reference model: next-start pointer, current owner (-1 none), streak
  bit         m_valid [3];
  logic [3:0] m_msg [3];
  int         m_ptr [3];
  int         m_own [3];
  int         m_run [3];

  function automatic int nc(int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic int nb(int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
  endfunction

  function automatic logic [3:0] pred(int d);
    logic [3:0] v;
    int c;
    int w;
    v = '0;
    c = nc(d);
    w = -1;
    if (reset || !(!m_valid[d] || rdy_s[d])) return v;
`ifdef BUS_FIXED_PRIO_EN
    if (wr_s[d][0]) return 4'b0001;
`endif
    for (int k = 0; k < c; k++)
      if (w < 0 && wr_s[d][(m_ptr[d] + k) % c]) w = (m_ptr[d] + k) % c;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  function automatic void adv(int d);
    logic [3:0] v;
    int w;
    v = pred(d);
    w = -1;
    for (int k = 0; k < 4; k++) if (v[k]) w = k;
    if (reset) begin
      m_valid[d] = 1'b0;
      m_msg[d]   = '0;
      m_ptr[d]   = 0;
      m_own[d]   = -1;
      m_run[d]   = 0;
      return;
    end
    if (m_valid[d] && !rdy_s[d]) return;
    if (w < 0) begin
      m_valid[d] = 1'b0;
      if (m_own[d] >= 0) m_ptr[d] = (m_own[d] + 1) % nc(d);
      m_own[d] = -1;
      m_run[d] = 0;
      return;
    end
    m_valid[d] = 1'b1;
    m_msg[d]   = mg_s[d][w];
`ifdef BUS_FIXED_PRIO_EN
    if (w == 0) return;
`endif
    if (w == m_own[d]) m_run[d]++;
    else begin
      m_own[d] = w;
      m_run[d] = 1;
    end
    if (m_run[d] >= nb(d)) begin
      m_ptr[d] = (w + 1) % nc(d);
      m_own[d] = -1;
      m_run[d] = 0;
    end else begin
      m_ptr[d] = w;
    end
  endfunction

  always @(posedge clock)
    for (int d = 0; d < 3; d++) adv(d);

  function automatic logic [3:0] sent_v(int d);
    case (d)
      0:       return ia.sent;
      1:       return ib.sent;
      default: return {1'b0, ic.sent};
    endcase
  endfunction

  function automatic logic valid_v(int d);
    case (d)
      0:       return ia.valid;
      1:       return ib.valid;
      default: return ic.valid;
    endcase
  endfunction

  function automatic logic [3:0] msg_v(int d);
    case (d)
      0:       return ia.message;
      1:       return ib.message;
      default: return ic.message;
    endcase
  endfunction

  task automatic set_all(input logic [3:0] w, input logic r);
    for (int d = 0; d < 3; d++) begin
      wr_s[d]  = w;
      rdy_s[d] = r;
      for (int i = 0; i < 4; i++) mg_s[d][i] = 4'(i);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    set_all(4'b0000, 1'b1);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      reset = (c < 2);
      set_all(4'b0000, 1'b1);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (sent_v(d) !== 4'b0000) begin
          errs++;
          $display("FAIL reset.sent d%0d got %b want 0000", d, sent_v(d));
        end
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (valid_v(d) !== 1'b0 || msg_v(d) !== 4'h0) begin
          errs++;
          $display("FAIL reset.out d%0d got v=%b m=%h want v=0 m=0",
                   d, valid_v(d), msg_v(d));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      set_all(4'b1111, 1'b1);
      #1;
      want = 4'b0001 << (c % 4);
      vecs++;
      if (sent_v(0) !== want) begin
        errs++;
        $display("FAIL rr.order c%0d got %b want %b", c, sent_v(0), want);
      end
      for (int d = 0; d < 3; d++) begin
        ex[d] = pred(d);
        vecs++;
        if (sent_v(d) !== ex[d]) begin
          errs++;
          $display("FAIL rr.sent d%0d got %b want %b", d, sent_v(d), ex[d]);
        end
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (valid_v(d) !== m_valid[d] || msg_v(d) !== m_msg[d]) begin
          errs++;
          $display("FAIL rr.out d%0d got v=%b m=%h want v=%b m=%h",
                   d, valid_v(d), msg_v(d), m_valid[d], m_msg[d]);
        end
      end
    end
  endtask

  task automatic test_skip_idle();
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      set_all((c == 0) ? 4'b0100 : 4'b0000, 1'b1);
      #1;
      vecs++;
      if (sent_v(0) !== ((c == 0) ? 4'b0100 : 4'b0000)) begin
        errs++;
        $display("FAIL skip.sent c%0d got %b", c, sent_v(0));
      end
      for (int d = 0; d < 3; d++) begin
        ex[d] = pred(d);
        vecs++;
        if (sent_v(d) !== ex[d]) begin
          errs++;
          $display("FAIL skip.model d%0d got %b want %b", d, sent_v(d), ex[d]);
        end
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (valid_v(d) !== m_valid[d] || msg_v(d) !== m_msg[d]) begin
          errs++;
          $display("FAIL skip.out d%0d got v=%b m=%h want v=%b m=%h",
                   d, valid_v(d), msg_v(d), m_valid[d], m_msg[d]);
        end
      end
    end
    vecs++;
    if (msg_v(0) !== 4'h2) begin
      errs++;
      $display("FAIL skip.msg got %h want 2", msg_v(0));
    end
  endtask

  task automatic test_burst();
    logic [3:0] seq [9];
    seq = '{4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h2, 4'h2, 4'h8};
    pulse_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      set_all((c < 8) ? 4'b1010 : 4'b1000, 1'b1);
      #1;
      if (c < 9) begin
        vecs++;
        if (sent_v(1) !== seq[c]) begin
          errs++;
          $display("FAIL burst.order c%0d got %b want %b", c, sent_v(1), seq[c]);
        end
      end
      for (int d = 0; d < 3; d++) begin
        ex[d] = pred(d);
        vecs++;
        if (sent_v(d) !== ex[d]) begin
          errs++;
          $display("FAIL burst.sent d%0d got %b want %b", d, sent_v(d), ex[d]);
        end
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (valid_v(d) !== m_valid[d] || msg_v(d) !== m_msg[d]) begin
          errs++;
          $display("FAIL burst.out d%0d got v=%b m=%h want v=%b m=%h",
                   d, valid_v(d), msg_v(d), m_valid[d], m_msg[d]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      set_all(4'b1111, !(c >= 2 && c < 6));
      #1;
      if (c >= 2 && c < 6) begin
        vecs++;
        if (sent_v(0) !== 4'b0000) begin
          errs++;
          $display("FAIL stall.sent c%0d got %b want 0000", c, sent_v(0));
        end
      end
      for (int d = 0; d < 3; d++) begin
        ex[d] = pred(d);
        vecs++;
        if (sent_v(d) !== ex[d]) begin
          errs++;
          $display("FAIL stall.model d%0d got %b want %b", d, sent_v(d), ex[d]);
        end
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (valid_v(d) !== m_valid[d] || msg_v(d) !== m_msg[d]) begin
          errs++;
          $display("FAIL stall.out d%0d got v=%b m=%h want v=%b m=%h",
                   d, valid_v(d), msg_v(d), m_valid[d], m_msg[d]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      set_all(4'b1111, 1'b1);
      reset = (c == 3 || c == 4);
      #1;
      if (c == 5) begin
        vecs++;
        if (sent_v(0) !== 4'b0001) begin
          errs++;
          $display("FAIL midrst.first got %b want 0001", sent_v(0));
        end
      end
      for (int d = 0; d < 3; d++) begin
        ex[d] = pred(d);
        vecs++;
        if (sent_v(d) !== ex[d]) begin
          errs++;
          $display("FAIL midrst.sent d%0d got %b want %b", d, sent_v(d), ex[d]);
        end
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (valid_v(d) !== m_valid[d] || msg_v(d) !== m_msg[d]) begin
          errs++;
          $display("FAIL midrst.out d%0d got v=%b m=%h want v=%b m=%h",
                   d, valid_v(d), msg_v(d), m_valid[d], m_msg[d]);
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    pulse_reset();
    for (int d = 0; d < 3; d++) ex[d] = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 4; i++) begin
          if (ex[d][i]) wr_s[d][i] = 1'b0;
          if (!wr_s[d][i] && $urandom_range(0, 2) != 0) begin
            wr_s[d][i] = 1'b1;
            mg_s[d][i] = 4'($urandom);
          end
        end
        rdy_s[d] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        ex[d] = pred(d);
        vecs++;
        if (sent_v(d) !== ex[d]) begin
          errs++;
          $display("FAIL rand.sent c%0d d%0d got %b want %b", c, d, sent_v(d), ex[d]);
        end
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (valid_v(d) !== m_valid[d] || msg_v(d) !== m_msg[d]) begin
          errs++;
          $display("FAIL rand.out c%0d d%0d got v=%b m=%h want v=%b m=%h",
                   c, d, valid_v(d), msg_v(d), m_valid[d], m_msg[d]);
        end
      end
    end
  endtask

`ifdef BUS_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    logic [3:0] pat [4];
    logic [3:0] seq [4];
    pat = '{4'b0010, 4'b0111, 4'b0110, 4'b0100};
    seq = '{4'b0010, 4'b0001, 4'b0010, 4'b0100};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      set_all(pat[c], 1'b1);
      #1;
      vecs++;
      if (sent_v(2) !== seq[c]) begin
        errs++;
        $display("FAIL prio.order c%0d got %b want %b", c, sent_v(2), seq[c]);
      end
      for (int d = 0; d < 3; d++) begin
        ex[d] = pred(d);
        vecs++;
        if (sent_v(d) !== ex[d]) begin
          errs++;
          $display("FAIL prio.sent d%0d got %b want %b", d, sent_v(d), ex[d]);
        end
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (valid_v(d) !== m_valid[d] || msg_v(d) !== m_msg[d]) begin
          errs++;
          $display("FAIL prio.out d%0d got v=%b m=%h want v=%b m=%h",
                   d, valid_v(d), msg_v(d), m_valid[d], m_msg[d]);
        end
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    set_all(4'b0000, 1'b1);
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_burst();
    test_backpressure();
    test_reset_midop();
`ifdef BUS_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
